// File: rtl/trap_ctrl_if.sv
// trap_interface: request/response channel between the trap controller and
// the pipeline flush logic. The requester drives req.mode; the responder
// holds res.flushflag high while the upstream flush is still in progress.
interface trap_interface;
  typedef struct packed {
    logic [1:0] mode;  // 0 = TRAP_NONE, 1 = TRAP_ENTER, 2 = TRAP_RETURN
  } trap_req_t;

  typedef struct packed {
    logic flushflag;
  } trap_res_t;

  trap_req_t req;
  trap_res_t res;

  modport requester (output req, input res);
  modport responder (input req, output res);
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller. It owns mtvec/mepc/mcause/mtval
// and mstatus.MIE/MPIE, and sequences trap entry and MRET toward the
// pipeline as IDLE -> ENTER|RETURN -> DRAIN -> IDLE.
// Optional feature: define TRAP_CTRL_IRQ_EN to add the timer interrupt path
// (2-flop synchronizer, mie.MTIE register and interrupt entry). Without it,
// irq_timer_i is ignored, mie reads as 0 and 0x304 writes are dropped.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        commit_valid_i,
  input  logic [31:0] commit_npc_i,
  input  logic        irq_timer_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mtval_o,
  output logic        mie_o,
  output logic        busy_o,
  trap_interface.requester trap_bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTER  = 2'd1;
  localparam logic [1:0] S_RETURN = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [1:0] TRAP_NONE   = 2'd0;
  localparam logic [1:0] TRAP_ENTER  = 2'd1;
  localparam logic [1:0] TRAP_RETURN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        irq_sync;
  logic        mtie;
  logic        unused_bits;

`ifdef TRAP_CTRL_IRQ_EN
  logic irq_meta_q, irq_sync_q;
  logic mtie_q, mtie_d;

  // Two-flop synchronizer for the asynchronous timer interrupt level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_meta_q <= 1'b0;
      irq_sync_q <= 1'b0;
    end else begin
      irq_meta_q <= irq_timer_i;
      irq_sync_q <= irq_meta_q;
    end
  end

  // mie.MTIE: only software writes to 0x304 change it
  always_ff @(posedge clk) begin
    if (!rst_n) mtie_q <= 1'b0;
    else        mtie_q <= mtie_d;
  end

  always_comb begin
    mtie_d = mtie_q;
    if (csr_we_i && csr_addr_i == 12'h304) mtie_d = csr_wdata_i[7];
  end

  assign irq_sync    = irq_sync_q;
  assign mtie        = mtie_q;
  assign unused_bits = ^{exc_pc_i[1:0], commit_npc_i[1:0]};
`else
  assign irq_sync    = 1'b0;
  assign mtie        = 1'b0;
  assign unused_bits = ^{exc_pc_i[1:0], commit_npc_i[1:0], irq_timer_i};
`endif

  // Next state: CSR writes first, trap/MRET updates afterwards so they win
  always_comb begin
    state_d  = state_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;

    if (csr_we_i) begin
      case (csr_addr_i)
        12'h300: begin
          mie_d  = csr_wdata_i[3];
          mpie_d = csr_wdata_i[7];
        end
        12'h305: mtvec_d  = {csr_wdata_i[31:2], 2'b00};
        12'h341: mepc_d   = {csr_wdata_i[31:2], 2'b00};
        12'h342: mcause_d = csr_wdata_i;
        12'h343: mtval_d  = csr_wdata_i;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        // Exceptions are never masked by MIE; at most one event per cycle
        if (exc_valid_i) begin
          mepc_d   = {exc_pc_i[31:2], 2'b00};
          mcause_d = {28'b0, exc_cause_i};
          mtval_d  = exc_tval_i;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
          state_d  = S_ENTER;
        end else if (mret_i) begin
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
          state_d = S_RETURN;
        end else if (irq_sync && mie_q && mtie && commit_valid_i) begin
          mepc_d   = {commit_npc_i[31:2], 2'b00};
          mcause_d = 32'h8000_0007;
          mtval_d  = 32'h0;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
          state_d  = S_ENTER;
        end
      end
      S_ENTER, S_RETURN: state_d = S_DRAIN;
      // Upstream is being flushed; new events here are dropped
      S_DRAIN: if (!trap_bus.res.flushflag) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and CSR registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mtvec_q  <= 32'h0;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
      mtval_q  <= 32'h0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  assign trap_bus.req.mode = (state_q == S_ENTER)  ? TRAP_ENTER  :
                             (state_q == S_RETURN) ? TRAP_RETURN : TRAP_NONE;

  assign mtvec_o  = mtvec_q;
  assign mepc_o   = mepc_q;
  assign mcause_o = mcause_q;
  assign mtval_o  = mtval_q;
  assign mie_o    = mie_q;
  assign busy_o   = (state_q != S_IDLE);
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl. Each expected trap request is
// queued when its stimulus is driven and popped when req.mode goes non-NONE.
module tb_trap_ctrl;
  localparam logic [1:0] M_NONE = 2'd0, M_ENTER = 2'd1, M_RETURN = 2'd2;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtvec;
    logic        mie;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid_i, mret_i, commit_valid_i, irq_timer_i, csr_we_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i, exc_tval_i, commit_npc_i, csr_wdata_i;
  logic [11:0] csr_addr_i;
  logic [31:0] mtvec_o, mepc_o, mcause_o, mtval_o;
  logic        mie_o, busy_o;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  trap_interface bus ();

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .mret_i(mret_i), .commit_valid_i(commit_valid_i),
    .commit_npc_i(commit_npc_i), .irq_timer_i(irq_timer_i),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mcause_o(mcause_o),
    .mtval_o(mtval_o), .mie_o(mie_o), .busy_o(busy_o),
    .trap_bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] mode, input logic [31:0] mepc,
                      input logic [31:0] mcause, input logic [31:0] mtvec,
                      input logic mie);
    exp_t e;
    e.mode = mode; e.mepc = mepc; e.mcause = mcause; e.mtvec = mtvec; e.mie = mie;
    sbq.push_back(e);
  endtask

  // Any non-NONE request must match the oldest queued expectation
  task automatic monitor();
    exp_t e;
    if (bus.req.mode !== M_NONE) begin
      if (sbq.size() == 0) begin
        chk("unexpected_req", {30'b0, bus.req.mode}, {30'b0, M_NONE});
      end else begin
        e = sbq.pop_front();
        chk("req_mode",   {30'b0, bus.req.mode}, {30'b0, e.mode});
        chk("req_mepc",   mepc_o,   e.mepc);
        chk("req_mcause", mcause_o, e.mcause);
        chk("req_mtvec",  mtvec_o,  e.mtvec);
        chk("req_mie",    {31'b0, mie_o}, {31'b0, e.mie});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
    tick();
    csr_we_i = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy_o) break;
      tick();
    end
    chk("wait_idle", {31'b0, busy_o}, 32'h0);
    chk("sb_drained", sbq.size(), 32'h0);
  endtask

  task automatic exc(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
    exc_valid_i = 1'b1; exc_cause_i = c; exc_pc_i = pc; exc_tval_i = tv;
  endtask

  initial begin
    rst_n = 1'b0; exc_valid_i = 0; mret_i = 0; commit_valid_i = 0; irq_timer_i = 0;
    csr_we_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0; commit_npc_i = 0;
    csr_addr_i = 0; csr_wdata_i = 0; bus.res.flushflag = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_busy",   {31'b0, busy_o}, 32'h0);
    chk("rst_mode",   {30'b0, bus.req.mode}, 32'h0);
    chk("rst_mtvec",  mtvec_o, 32'h0);
    chk("rst_mepc",   mepc_o, 32'h0);
    chk("rst_mcause", mcause_o, 32'h0);
    chk("rst_mtval",  mtval_o, 32'h0);
    chk("rst_mie",    {31'b0, mie_o}, 32'h0);

    // mtvec low bits are forced to zero
    csr_wr(12'h305, 32'h0000_0103);
    chk("mtvec_wr", mtvec_o, 32'h0000_0100);

    // Basic exception entry
    push(M_ENTER, 32'h80, 32'h2, 32'h100, 1'b0);
    exc(4'd2, 32'h80, 32'h55);
    tick();
    exc_valid_i = 0;
    chk("exc_busy",  {31'b0, busy_o}, 32'h1);
    chk("exc_mtval", mtval_o, 32'h55);
    wait_idle(10);

    // MRET with MPIE=1: MIE restored, mepc untouched
    csr_wr(12'h300, 32'h80);
    chk("mstatus_mie0", {31'b0, mie_o}, 32'h0);
    push(M_RETURN, 32'h80, 32'h2, 32'h100, 1'b1);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("mret_busy", {31'b0, busy_o}, 32'h1);
    wait_idle(10);

    // Exception and MRET together: exception wins, no RETURN; unaligned PC
    push(M_ENTER, 32'h84, 32'h5, 32'h100, 1'b0);
    exc(4'd5, 32'h86, 32'h1234); mret_i = 1'b1;
    tick();
    exc_valid_i = 0; mret_i = 0;
    chk("excmret_tval", mtval_o, 32'h1234);
    wait_idle(10);
    push(M_RETURN, 32'h84, 32'h5, 32'h100, 1'b1);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    wait_idle(10);

    // DRAIN held by flushflag; second exception in DRAIN ignored
    push(M_ENTER, 32'h100, 32'h7, 32'h100, 1'b0);
    bus.res.flushflag = 1'b1;
    exc(4'd7, 32'h100, 32'h0);
    tick();
    exc_valid_i = 0;
    tick();
    chk("drain_c1", {31'b0, busy_o}, 32'h1);
    exc(4'd3, 32'h300, 32'h9);
    tick();
    chk("drain_c2", {31'b0, busy_o}, 32'h1);
    tick();
    chk("drain_c3", {31'b0, busy_o}, 32'h1);
    bus.res.flushflag = 1'b0; exc_valid_i = 0;
    tick();
    chk("drain_exit", {31'b0, busy_o}, 32'h0);
    chk("drain_mepc", mepc_o, 32'h100);
    chk("drain_mcause", mcause_o, 32'h7);
    wait_idle(10);

    // Timer interrupt
    csr_wr(12'h300, 32'h08);
    csr_wr(12'h304, 32'h80);
    commit_valid_i = 1'b1; commit_npc_i = 32'h200; irq_timer_i = 1'b1;
`ifdef TRAP_CTRL_IRQ_EN
    tick();
    chk("irq_e1", {31'b0, busy_o}, 32'h0);
    tick();
    chk("irq_e2", {31'b0, busy_o}, 32'h0);
    push(M_ENTER, 32'h200, 32'h8000_0007, 32'h100, 1'b0);
    tick();
    chk("irq_e3", {31'b0, busy_o}, 32'h1);
    chk("irq_mtval", mtval_o, 32'h0);
    irq_timer_i = 0; commit_valid_i = 0;
    wait_idle(10);
`else
    for (int i = 0; i < 5; i++) tick();
    chk("irq_disabled", {31'b0, busy_o}, 32'h0);
    irq_timer_i = 0; commit_valid_i = 0;
`endif
    csr_wr(12'h300, 32'h80);

    // Exception beats a same-cycle mepc write; MPIE picks up MIE=0
    push(M_ENTER, 32'h40, 32'h1, 32'h100, 1'b0);
    exc(4'd1, 32'h40, 32'h77);
    csr_we_i = 1'b1; csr_addr_i = 12'h341; csr_wdata_i = 32'h999;
    tick();
    exc_valid_i = 0; csr_we_i = 0;
    chk("prio_mepc", mepc_o, 32'h40);
    wait_idle(10);
    csr_wr(12'h341, 32'h1237);
    chk("csr_mepc", mepc_o, 32'h1234);
    csr_wr(12'h342, 32'hdead_beef);
    chk("csr_mcause", mcause_o, 32'hdead_beef);
    csr_wr(12'h343, 32'hcafe);
    chk("csr_mtval", mtval_o, 32'hcafe);
    csr_wr(12'h344, 32'h1111);
    chk("csr_unmapped", mtval_o, 32'hcafe);
    // MRET beats a same-cycle mstatus write; MIE <= MPIE (0)
    push(M_RETURN, 32'h1234, 32'hdead_beef, 32'h100, 1'b0);
    mret_i = 1'b1;
    csr_we_i = 1'b1; csr_addr_i = 12'h300; csr_wdata_i = 32'h08;
    tick();
    mret_i = 0; csr_we_i = 0;
    chk("prio_mret_mie", {31'b0, mie_o}, 32'h0);
    wait_idle(10);

    // Reset while in DRAIN
    push(M_ENTER, 32'h10, 32'h4, 32'h100, 1'b0);
    bus.res.flushflag = 1'b1;
    exc(4'd4, 32'h10, 32'h0);
    tick();
    exc_valid_i = 0;
    tick();
    chk("pre_rst_drain", {31'b0, busy_o}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; bus.res.flushflag = 1'b0;
    chk("rst2_busy",   {31'b0, busy_o}, 32'h0);
    chk("rst2_mode",   {30'b0, bus.req.mode}, 32'h0);
    chk("rst2_mtvec",  mtvec_o, 32'h0);
    chk("rst2_mepc",   mepc_o, 32'h0);
    chk("rst2_mcause", mcause_o, 32'h0);
    chk("rst2_mtval",  mtval_o, 32'h0);
    chk("rst2_mie",    {31'b0, mie_o}, 32'h0);
    tick();
    chk("rst2_idle", {31'b0, busy_o}, 32'h0);
    chk("sb_final", sbq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
